arbitro_ula: RTL and testbench

ARBITRO_ULA -- requirements
Module: arbitro_ula

---
 rtl/ula_pkg.sv | 43 ++++
 rtl/arbitro_ula_if.sv | 53 +++++
 rtl/rr_arbitro.sv | 35 +++
 rtl/arbitro_ula.sv | 140 ++++++++++++++
 tb/tb_arbitro_ula.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ula_pkg.sv
// Shared definitions for the ALU arbiter: opcode names, default widths and
// the opcode sets whose ALU flags are meaningful.
package ula_pkg;

    localparam int unsigned NUM_REQ_PADRAO = 3;
    localparam int unsigned TAG_W_PADRAO   = 3;
    localparam int unsigned DADO_W         = 16;
    localparam int unsigned CODOP_W        = 4;

    localparam logic [CODOP_W-1:0] COD_ADD  = 4'd0;
    localparam logic [CODOP_W-1:0] COD_SUB  = 4'd1;
    localparam logic [CODOP_W-1:0] COD_AND  = 4'd2;
    localparam logic [CODOP_W-1:0] COD_OR   = 4'd3;
    localparam logic [CODOP_W-1:0] COD_XOR  = 4'd4;
    localparam logic [CODOP_W-1:0] COD_NOT  = 4'd5;
    localparam logic [CODOP_W-1:0] COD_SHL  = 4'd6;
    localparam logic [CODOP_W-1:0] COD_SHR  = 4'd7;
    localparam logic [CODOP_W-1:0] COD_SAR  = 4'd8;
    localparam logic [CODOP_W-1:0] COD_INC  = 4'd9;
    localparam logic [CODOP_W-1:0] COD_DEC  = 4'd10;
    localparam logic [CODOP_W-1:0] COD_NOP  = 4'd11;
    localparam logic [CODOP_W-1:0] COD_SELZ = 4'd12;

    typedef struct packed {
        logic neg;
        logic zero;
        logic overflow;
    } flags_t;

    // neg/overflow are only meaningful for the arithmetic opcodes
    function automatic logic codop_nv_valido(input logic [CODOP_W-1:0] c);
        return (c == COD_ADD) || (c == COD_SUB) || (c == COD_INC) || (c == COD_DEC);
    endfunction

    function automatic logic codop_z_valido(input logic [CODOP_W-1:0] c);
        return c == COD_SELZ;
    endfunction

    function automatic logic codop_reservado(input logic [CODOP_W-1:0] c);
        return c > COD_SELZ;
    endfunction

endpackage

// File: rtl/arbitro_ula_if.sv
// Request, shared-ALU and result-broadcast signals of the ALU arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface arbitro_ula_if #(
    parameter int unsigned NUM_REQ = ula_pkg::NUM_REQ_PADRAO,
    parameter int unsigned TAG_W   = ula_pkg::TAG_W_PADRAO
);

    logic [NUM_REQ-1:0]                   req_valido;
    logic [ula_pkg::CODOP_W*NUM_REQ-1:0]  req_codop;
    logic [ula_pkg::DADO_W*NUM_REQ-1:0]   req_op1;
    logic [ula_pkg::DADO_W*NUM_REQ-1:0]   req_op2;
    logic [TAG_W*NUM_REQ-1:0]             req_tag;
    logic [NUM_REQ-1:0]                   req_aceito;

    logic [ula_pkg::CODOP_W-1:0]          ula_codop;
    logic [ula_pkg::DADO_W-1:0]           ula_operando1;
    logic [ula_pkg::DADO_W-1:0]           ula_operando2;
    logic [ula_pkg::DADO_W-1:0]           ula_resultado;
    logic                                 ula_neg;
    logic                                 ula_zero;
    logic                                 ula_overflow;

    logic                                 cdb_valido;
    logic [TAG_W-1:0]                     cdb_tag;
    logic [ula_pkg::DADO_W-1:0]           cdb_resultado;
    logic                                 cdb_neg;
    logic                                 cdb_zero;
    logic                                 cdb_overflow;
    logic                                 cdb_pronto;

    logic                                 ocupado;

    modport slave (
        input  req_valido, req_codop, req_op1, req_op2, req_tag,
        output req_aceito,
        output ula_codop, ula_operando1, ula_operando2,
        input  ula_resultado, ula_neg, ula_zero, ula_overflow,
        output cdb_valido, cdb_tag, cdb_resultado, cdb_neg, cdb_zero, cdb_overflow,
        input  cdb_pronto,
        output ocupado
    );

    modport master (
        output req_valido, req_codop, req_op1, req_op2, req_tag,
        input  req_aceito,
        input  ula_codop, ula_operando1, ula_operando2,
        output ula_resultado, ula_neg, ula_zero, ula_overflow,
        input  cdb_valido, cdb_tag, cdb_resultado, cdb_neg, cdb_zero, cdb_overflow,
        output cdb_pronto,
        input  ocupado
    );

endinterface

// File: rtl/rr_arbitro.sv
// Round-robin selector: one-hot grant to the first requester at or after the
// pointer, wrapping around to index 0.
module rr_arbitro #(
    parameter int unsigned N     = 3,
    parameter int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt,
    output logic [PTR_W-1:0] o_idx,
    output logic             o_valido
);

    always_comb begin
        o_gnt    = '0;
        o_idx    = '0;
        o_valido = 1'b0;
        // Upper segment [ptr, N) has priority over the wrapped segment [0, ptr).
        for (int unsigned i = 0; i < N; i++) begin
            if (!o_valido && i_req[i] && (i >= 32'(i_ptr))) begin
                o_gnt[i] = 1'b1;
                o_idx    = PTR_W'(i);
                o_valido = 1'b1;
            end
        end
        for (int unsigned i = 0; i < N; i++) begin
            if (!o_valido && i_req[i] && (i < 32'(i_ptr))) begin
                o_gnt[i] = 1'b1;
                o_idx    = PTR_W'(i);
                o_valido = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arbitro_ula.sv
// Shares one external ALU among NUM_REQ requesters through an execute (E) and
// writeback (W) pipeline, broadcasting tagged results on the CDB.
module arbitro_ula import ula_pkg::*; #(
    parameter int unsigned NUM_REQ = NUM_REQ_PADRAO,
    parameter int unsigned TAG_W   = TAG_W_PADRAO
) (
    input logic          clk,
    input logic          reset_n,
    arbitro_ula_if.slave bus
);

    localparam int unsigned      PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(NUM_REQ - 1);

    logic [PTR_W-1:0]   r_ptr;

    logic               r_e_valido;
    logic [CODOP_W-1:0] r_e_codop;
    logic [DADO_W-1:0]  r_e_op1;
    logic [DADO_W-1:0]  r_e_op2;
    logic [TAG_W-1:0]   r_e_tag;

    logic               r_w_valido;
    logic [TAG_W-1:0]   r_w_tag;
    logic [DADO_W-1:0]  r_w_res;
    flags_t             r_w_flags;

    logic               w_w_avanca;
    logic               w_pode_conceder;
    logic               w_concede;
    logic [NUM_REQ-1:0] w_req_elegivel;
    logic [NUM_REQ-1:0] w_gnt;
    logic [PTR_W-1:0]   w_gnt_idx;

    logic [CODOP_W-1:0] w_sel_codop;
    logic [DADO_W-1:0]  w_sel_op1;
    logic [DADO_W-1:0]  w_sel_op2;
    logic [TAG_W-1:0]   w_sel_tag;

    logic [DADO_W-1:0]  w_cap_res;
    flags_t             w_cap_flags;

    assign w_w_avanca = !r_w_valido || bus.cdb_pronto;

    // E can take a new entry when empty or when it moves into W this cycle.
    assign w_pode_conceder = reset_n && (!r_e_valido || w_w_avanca);
    assign w_req_elegivel  = bus.req_valido & {NUM_REQ{w_pode_conceder}};

    rr_arbitro #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .i_req    (w_req_elegivel),
        .i_ptr    (r_ptr),
        .o_gnt    (w_gnt),
        .o_idx    (w_gnt_idx),
        .o_valido (w_concede)
    );

    assign bus.req_aceito = w_gnt;

    always_comb begin
        w_sel_codop = '0;
        w_sel_op1   = '0;
        w_sel_op2   = '0;
        w_sel_tag   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_codop = bus.req_codop[CODOP_W*i +: CODOP_W];
                w_sel_op1   = bus.req_op1[DADO_W*i +: DADO_W];
                w_sel_op2   = bus.req_op2[DADO_W*i +: DADO_W];
                w_sel_tag   = bus.req_tag[TAG_W*i +: TAG_W];
            end
        end
    end

    // Idle ALU sees a NOP with zero operands.
    assign bus.ula_codop     = r_e_valido ? r_e_codop : COD_NOP;
    assign bus.ula_operando1 = r_e_valido ? r_e_op1 : '0;
    assign bus.ula_operando2 = r_e_valido ? r_e_op2 : '0;

    always_comb begin
        w_cap_res            = bus.ula_resultado;
        w_cap_flags          = '0;
        w_cap_flags.neg      = codop_nv_valido(r_e_codop) & bus.ula_neg;
        w_cap_flags.overflow = codop_nv_valido(r_e_codop) & bus.ula_overflow;
        w_cap_flags.zero     = codop_z_valido(r_e_codop) & bus.ula_zero;
        if (codop_reservado(r_e_codop)) begin
            w_cap_res = '0;
        end else if ((r_e_codop == COD_SELZ) && (r_e_op1 != '0)) begin
            w_cap_res        = '0;
            w_cap_flags.zero = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ptr      <= '0;
            r_e_valido <= 1'b0;
            r_e_codop  <= '0;
            r_e_op1    <= '0;
            r_e_op2    <= '0;
            r_e_tag    <= '0;
            r_w_valido <= 1'b0;
            r_w_tag    <= '0;
            r_w_res    <= '0;
            r_w_flags  <= '0;
        end else begin
            if (w_concede) begin
                r_ptr <= (w_gnt_idx == PTR_MAX) ? '0 : w_gnt_idx + 1'b1;
            end
            if (w_pode_conceder) begin
                r_e_valido <= w_concede;
                if (w_concede) begin
                    r_e_codop <= w_sel_codop;
                    r_e_op1   <= w_sel_op1;
                    r_e_op2   <= w_sel_op2;
                    r_e_tag   <= w_sel_tag;
                end
            end
            if (w_w_avanca) begin
                r_w_valido <= r_e_valido;
                if (r_e_valido) begin
                    r_w_tag   <= r_e_tag;
                    r_w_res   <= w_cap_res;
                    r_w_flags <= w_cap_flags;
                end
            end
        end
    end

    assign bus.cdb_valido    = r_w_valido;
    assign bus.cdb_tag       = r_w_tag;
    assign bus.cdb_resultado = r_w_res;
    assign bus.cdb_neg       = r_w_flags.neg;
    assign bus.cdb_zero      = r_w_flags.zero;
    assign bus.cdb_overflow  = r_w_flags.overflow;
    assign bus.ocupado       = r_e_valido || r_w_valido;

endmodule

// File: tb/tb_arbitro_ula.sv
// Directed bench for arbitro_ula: a behavioural ALU model plus hand-computed
// expected grants and CDB broadcasts.
module tb_arbitro_ula;

    logic clk;
    logic reset_n;
    int   n_vet = 0;
    int   n_err = 0;

    arbitro_ula_if #(.NUM_REQ(3), .TAG_W(3)) bus ();

    arbitro_ula #(
        .NUM_REQ (3),
        .TAG_W   (3)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU; codop 12 returns op2 unconditionally so the arbiter's
    // masking for op1 != 0 is observable.
    logic [15:0] a, b, r;
    logic        ov;
    always_comb begin
        a  = bus.ula_operando1;
        b  = bus.ula_operando2;
        r  = a;
        ov = 1'b0;
        case (bus.ula_codop)
            4'd0: begin r = a + b; ov = (a[15] == b[15]) && (r[15] != a[15]); end
            4'd1: begin r = a - b; ov = (a[15] != b[15]) && (r[15] != a[15]); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = ~a;
            4'd6: r = a << 1;
            4'd7: r = a >> 1;
            4'd8: r = $signed(a) >>> 1;
            4'd9: begin r = a + 16'd1; ov = !a[15] && r[15]; end
            4'd10: begin r = a - 16'd1; ov = a[15] && !r[15]; end
            4'd12: r = b;
            default: r = a;
        endcase
        bus.ula_resultado = r;
        bus.ula_neg       = r[15];
        bus.ula_overflow  = ov;
        bus.ula_zero      = (bus.ula_codop == 4'd12) ? (a == 16'h0) : (r == 16'h0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vet++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observado=0x%0h esperado=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic ver_cdb(input string t, input logic [2:0] tag, input logic [15:0] res,
                           input logic n, input logic z, input logic v);
        chk({t, ".valido"}, 32'(bus.cdb_valido), 32'h1);
        chk({t, ".tag"}, 32'(bus.cdb_tag), 32'(tag));
        chk({t, ".res"}, 32'(bus.cdb_resultado), 32'(res));
        chk({t, ".neg"}, 32'(bus.cdb_neg), 32'(n));
        chk({t, ".zero"}, 32'(bus.cdb_zero), 32'(z));
        chk({t, ".ovf"}, 32'(bus.cdb_overflow), 32'(v));
    endtask

    task automatic pede(input int i, input logic [3:0] c, input logic [15:0] x,
                        input logic [15:0] y, input logic [2:0] t);
        bus.req_valido             = '0;
        bus.req_valido[i]          = 1'b1;
        bus.req_codop[4*i +: 4]    = c;
        bus.req_op1[16*i +: 16]    = x;
        bus.req_op2[16*i +: 16]    = y;
        bus.req_tag[3*i +: 3]      = t;
    endtask

    initial begin
        reset_n        = 1'b0;
        bus.req_valido = '0;
        bus.req_codop  = '0;
        bus.req_op1    = '0;
        bus.req_op2    = '0;
        bus.req_tag    = '0;
        bus.cdb_pronto = 1'b1;

        @(negedge clk);
        bus.req_valido = 3'b111;
        #1;
        chk("rst.aceito0", 32'(bus.req_aceito), 32'h0);
        @(negedge clk);
        #1;
        chk("rst.aceito1", 32'(bus.req_aceito), 32'h0);
        chk("rst.cdb_valido", 32'(bus.cdb_valido), 32'h0);
        chk("rst.ocupado", 32'(bus.ocupado), 32'h0);
        chk("rst.ula_codop", 32'(bus.ula_codop), 32'd11);
        chk("rst.ula_op1", 32'(bus.ula_operando1), 32'h0);
        chk("rst.cdb_res", 32'(bus.cdb_resultado), 32'h0);

        // First cycle out of reset: single ADD with overflow.
        @(negedge clk);
        reset_n = 1'b1;
        pede(0, 4'd0, 16'h7FFF, 16'h0001, 3'd5);
        #1;
        chk("add.gnt", 32'(bus.req_aceito), 32'h1);
        @(negedge clk);
        bus.req_valido = '0;
        #1;
        chk("add.gnt_idle", 32'(bus.req_aceito), 32'h0);
        chk("add.ula_codop", 32'(bus.ula_codop), 32'h0);
        chk("add.ula_op1", 32'(bus.ula_operando1), 32'h7FFF);
        chk("add.ula_op2", 32'(bus.ula_operando2), 32'h0001);
        chk("add.ocupado", 32'(bus.ocupado), 32'h1);
        chk("add.cdb_cedo", 32'(bus.cdb_valido), 32'h0);
        @(negedge clk);
        #1;
        ver_cdb("add", 3'd5, 16'h8000, 1'b1, 1'b0, 1'b1);

        // Flag masking, codop 12 and reserved codop 14.
        @(negedge clk);
        pede(1, 4'd1, 16'h0000, 16'h0001, 3'd1);
        #1;
        chk("drain.cdb_valido", 32'(bus.cdb_valido), 32'h0);
        chk("drain.ocupado", 32'(bus.ocupado), 32'h0);
        chk("sub.gnt", 32'(bus.req_aceito), 32'h2);
        @(negedge clk);
        pede(2, 4'd3, 16'h8000, 16'h0001, 3'd2);
        #1;
        chk("or.gnt", 32'(bus.req_aceito), 32'h4);
        chk("sub.ula_codop", 32'(bus.ula_codop), 32'h1);
        @(negedge clk);
        pede(0, 4'd12, 16'h0000, 16'h00AA, 3'd3);
        #1;
        chk("selz0.gnt", 32'(bus.req_aceito), 32'h1);
        ver_cdb("sub", 3'd1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        pede(1, 4'd14, 16'h1234, 16'h5555, 3'd6);
        #1;
        chk("cod14.gnt", 32'(bus.req_aceito), 32'h2);
        ver_cdb("or_mask", 3'd2, 16'h8001, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        pede(2, 4'd12, 16'h0001, 16'h00BB, 3'd7);
        #1;
        chk("selz1.gnt", 32'(bus.req_aceito), 32'h4);
        ver_cdb("selz0", 3'd3, 16'h00AA, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        bus.req_valido = '0;
        #1;
        ver_cdb("cod14", 3'd6, 16'h0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        ver_cdb("selz1", 3'd7, 16'h0000, 1'b0, 1'b0, 1'b0);

        // Round robin with all three requesting: requester i adds (i<<8)+1, tag i+4.
        for (int i = 0; i < 3; i++) begin
            bus.req_codop[4*i +: 4] = 4'd0;
            bus.req_op1[16*i +: 16] = 16'(i << 8);
            bus.req_op2[16*i +: 16] = 16'h0001;
            bus.req_tag[3*i +: 3]   = 3'(i + 4);
        end
        for (int k = 0; k < 8; k++) begin
            int j;
            @(negedge clk);
            bus.req_valido = (k < 6) ? 3'b111 : 3'b000;
            #1;
            chk("rr.gnt", 32'(bus.req_aceito), (k < 6) ? (32'h1 << (k % 3)) : 32'h0);
            if (k >= 2) begin
                j = (k - 2) % 3;
                ver_cdb("rr", 3'(j + 4), 16'((j << 8) + 1), 1'b0, 1'b0, 1'b0);
            end else begin
                chk("rr.cdb_vazio", 32'(bus.cdb_valido), 32'h0);
            end
        end

        // Backpressure: fill E and W, stall the CDB for four cycles, release.
        @(negedge clk);
        bus.req_valido = 3'b111;
        #1;
        chk("bp.gnt0", 32'(bus.req_aceito), 32'h1);
        @(negedge clk);
        #1;
        chk("bp.gnt1", 32'(bus.req_aceito), 32'h2);
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            bus.cdb_pronto = 1'b0;
            #1;
            chk("bp.gnt_stall", 32'(bus.req_aceito), 32'h0);
            chk("bp.ocupado", 32'(bus.ocupado), 32'h1);
            ver_cdb("bp.hold", 3'd4, 16'h0001, 1'b0, 1'b0, 1'b0);
        end
        @(negedge clk);
        bus.cdb_pronto = 1'b1;
        #1;
        chk("bp.gnt_release", 32'(bus.req_aceito), 32'h4);
        ver_cdb("bp.r0", 3'd4, 16'h0001, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        bus.req_valido = '0;
        #1;
        ver_cdb("bp.r1", 3'd5, 16'h0101, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        ver_cdb("bp.r2", 3'd6, 16'h0201, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        chk("bp.vazio", 32'(bus.cdb_valido), 32'h0);

        // Reset with E and W occupied and the pointer left at 2.
        @(negedge clk);
        bus.req_valido = 3'b011;
        #1;
        chk("rm.gnt0", 32'(bus.req_aceito), 32'h1);
        @(negedge clk);
        bus.req_valido = 3'b010;
        #1;
        chk("rm.gnt1", 32'(bus.req_aceito), 32'h2);
        @(negedge clk);
        reset_n        = 1'b0;
        bus.req_valido = 3'b111;
        #1;
        chk("rm.gnt_rst", 32'(bus.req_aceito), 32'h0);
        chk("rm.ocupado_antes", 32'(bus.ocupado), 32'h1);
        chk("rm.cdb_antes", 32'(bus.cdb_valido), 32'h1);
        @(negedge clk);
        reset_n        = 1'b1;
        bus.req_valido = 3'b101;
        #1;
        chk("rm.cdb_valido", 32'(bus.cdb_valido), 32'h0);
        chk("rm.ocupado", 32'(bus.ocupado), 32'h0);
        chk("rm.cdb_tag", 32'(bus.cdb_tag), 32'h0);
        chk("rm.cdb_res", 32'(bus.cdb_resultado), 32'h0);
        chk("rm.ula_codop", 32'(bus.ula_codop), 32'd11);
        chk("rm.gnt_low", 32'(bus.req_aceito), 32'h1);
        @(negedge clk);
        bus.req_valido = '0;
        #1;
        chk("rm.ula_codop_e", 32'(bus.ula_codop), 32'h0);
        @(negedge clk);
        #1;
        ver_cdb("rm.res", 3'd4, 16'h0001, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        chk("rm.fim_valido", 32'(bus.cdb_valido), 32'h0);
        chk("rm.fim_ocupado", 32'(bus.ocupado), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vet, n_err);
        $finish;
    end

endmodule
